// File: rtl/frame_sequencer.sv
// frame_sequencer: meters RX FIFO bytes into the line buffer one full line per burst
// under line-buffer credits, counts Sobel results and flags frame completion.
// Define FRAME_TIMEOUT_EN to build the stall-abort counter (timeout tied low otherwise).
module frame_sequencer #(
   parameter int unsigned IMG_W       = 512,
   parameter int unsigned IMG_H       = 512,
   parameter int unsigned LB_LINES    = 4,
   parameter int unsigned OUT_PIX     = 261120,
`ifdef FRAME_TIMEOUT_EN
   parameter int unsigned TIMEOUT_CYC = 1000000,
`endif
   parameter int unsigned LINE_W      = 10,
   parameter int unsigned OPIX_W      = 18
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [13:0]       rx_fifo_capacity,
   output logic              read_req,
   output logic              read_data_valid,
   input  logic              lb_intr,
   input  logic              sobel_valid,
   output logic              frame_busy,
   output logic              frame_done,
   output logic              timeout,
   output logic [LINE_W-1:0] line_count,
   output logic [OPIX_W-1:0] out_pix_count
);

   localparam int unsigned COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned CRED_W = $clog2(LB_LINES + 1);

   localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_W - 1);
   localparam logic [CRED_W-1:0] CRED_MAX   = CRED_W'(LB_LINES);
   localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(IMG_H);
   localparam logic [OPIX_W-1:0] OPIX_TGT   = OPIX_W'(OUT_PIX);
   localparam logic [13:0]       LINE_BYTES = 14'(IMG_W);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_BURST = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [CRED_W-1:0] credits_q, credits_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic [OPIX_W-1:0] opix_q, opix_d;
   logic              read_req_q, read_req_d;
   logic              rdv_q, rdv_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;

   logic              line_ready;
   logic              cred_take;
   logic [LINE_W-1:0] line_inc;

   assign line_ready = (rx_fifo_capacity >= LINE_BYTES);
   assign cred_take  = (state_q == S_BURST) && (col_q == '0);
   assign line_inc   = line_q + LINE_W'(1);

`ifdef FRAME_TIMEOUT_EN
   localparam int unsigned STALL_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);
   logic [STALL_W-1:0] stall_q, stall_d;
`endif

   // next-state, counters and registered-output values
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      line_d    = line_q;
      opix_d    = opix_q;
      credits_d = credits_q;
      timeout_d = 1'b0;

      if (lb_intr && !cred_take && (credits_q != CRED_MAX)) begin
         credits_d = credits_q + CRED_W'(1);
      end else if (cred_take && !lb_intr) begin
         credits_d = credits_q - CRED_W'(1);
      end

      if (sobel_valid && (state_q inside {S_WAIT, S_BURST, S_DRAIN}) && (opix_q != '1)) begin
         opix_d = opix_q + OPIX_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            credits_d = CRED_MAX;
            line_d    = '0;
            opix_d    = '0;
            col_d     = '0;
            if (line_ready) begin
               state_d = S_BURST;
            end
         end
         S_WAIT: begin
            if ((credits_q != '0) && line_ready) begin
               state_d = S_BURST;
               col_d   = '0;
            end
         end
         S_BURST: begin
            if (col_q == COL_LAST) begin
               col_d   = '0;
               line_d  = line_inc;
               state_d = (line_inc == LINE_LAST) ? S_DRAIN : S_WAIT;
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end
         S_DRAIN: begin
            if (opix_q >= OPIX_TGT) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d   = S_IDLE;
            line_d    = '0;
            opix_d    = '0;
            col_d     = '0;
            credits_d = CRED_MAX;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef FRAME_TIMEOUT_EN
      // stall abort overrides normal sequencing
      stall_d = stall_q;
      if (read_req_q || sobel_valid || (state_q == S_IDLE)) begin
         stall_d = '0;
      end else if (stall_q == STALL_LAST) begin
         stall_d   = '0;
         state_d   = S_IDLE;
         col_d     = '0;
         line_d    = '0;
         opix_d    = '0;
         credits_d = CRED_MAX;
         timeout_d = 1'b1;
      end else begin
         stall_d = stall_q + STALL_W'(1);
      end
`endif

      read_req_d = (state_d == S_BURST);
      rdv_d      = read_req_q;
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         col_q      <= '0;
         credits_q  <= CRED_MAX;
         line_q     <= '0;
         opix_q     <= '0;
         read_req_q <= 1'b0;
         rdv_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         credits_q  <= credits_d;
         line_q     <= line_d;
         opix_q     <= opix_d;
         read_req_q <= read_req_d;
         rdv_q      <= rdv_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
      end
   end

`ifdef FRAME_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end
`endif

   assign read_req        = read_req_q;
   assign read_data_valid = rdv_q;
   assign frame_busy      = busy_q;
   assign frame_done      = done_q;
   assign timeout         = timeout_q;
   assign line_count      = line_q;
   assign out_pix_count   = opix_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: expected line counts are queued per burst
// and checked by a burst monitor; scenario tasks check counters, done and timeout.
module tb_frame_sequencer;

   localparam int unsigned IMG_W       = 8;
   localparam int unsigned IMG_H       = 6;
   localparam int unsigned LB_LINES    = 4;
   localparam int unsigned OUT_PIX     = 24;
   localparam int unsigned TIMEOUT_CYC = 100;
   localparam int unsigned LINE_W      = 10;
   localparam int unsigned OPIX_W      = 18;

   logic              clk = 1'b0;
   logic              reset;
   logic [13:0]       rx_fifo_capacity;
   logic              read_req;
   logic              read_data_valid;
   logic              lb_intr;
   logic              sobel_valid;
   logic              frame_busy;
   logic              frame_done;
   logic              timeout;
   logic [LINE_W-1:0] line_count;
   logic [OPIX_W-1:0] out_pix_count;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_lines[$];
   bit mon_en   = 1'b0;
   int run_len  = 0;
   logic prev_rr = 1'b0;

   frame_sequencer #(
      .IMG_W      (IMG_W),
      .IMG_H      (IMG_H),
      .LB_LINES   (LB_LINES),
      .OUT_PIX    (OUT_PIX),
`ifdef FRAME_TIMEOUT_EN
      .TIMEOUT_CYC(TIMEOUT_CYC),
`endif
      .LINE_W     (LINE_W),
      .OPIX_W     (OPIX_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .rx_fifo_capacity(rx_fifo_capacity),
      .read_req        (read_req),
      .read_data_valid (read_data_valid),
      .lb_intr         (lb_intr),
      .sobel_valid     (sobel_valid),
      .frame_busy      (frame_busy),
      .frame_done      (frame_done),
      .timeout         (timeout),
      .line_count      (line_count),
      .out_pix_count   (out_pix_count)
   );

   always #5 clk = ~clk;

   // burst monitor: burst length, read_data_valid lag, and line count popped from the scoreboard
   always @(negedge clk) begin
      if (!mon_en || reset) begin
         run_len = 0;
         prev_rr = 1'b0;
      end else begin
         n_checks++;
         if (read_data_valid !== prev_rr) begin
            n_fail++;
            $display("FAIL rdv_lag: got %0b expected %0b at %0t", read_data_valid, prev_rr, $time);
         end
         if (read_req === 1'b1) begin
            run_len++;
         end else if (run_len != 0) begin
            n_checks++;
            if (run_len != IMG_W) begin
               n_fail++;
               $display("FAIL burst_len: got %0d expected %0d at %0t", run_len, IMG_W, $time);
            end
            n_checks++;
            if (exp_lines.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_burst: got burst with line_count %0d expected none at %0t", line_count, $time);
            end else begin
               int e;
               e = exp_lines.pop_front();
               if (line_count !== LINE_W'(e)) begin
                  n_fail++;
                  $display("FAIL burst_line_count: got %0d expected %0d at %0t", line_count, e, $time);
               end
            end
            run_len = 0;
         end
         prev_rr = read_req;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      reset = 1'b1;
      rx_fifo_capacity = '0;
      lb_intr = 1'b0;
      sobel_valid = 1'b0;
      tick(2);
      exp_lines.delete();
      reset = 1'b0;
      tick(1);
      mon_en = 1'b1;
   endtask

   task automatic test_reset();
      mon_en = 1'b0;
      reset = 1'b1;
      rx_fifo_capacity = 14'd64;
      lb_intr = 1'b0;
      sobel_valid = 1'b1;
      tick(3);
      n_checks++; if (read_req !== 1'b0) begin n_fail++; $display("FAIL reset_read_req: got %0b expected 0", read_req); end
      n_checks++; if (read_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rdv: got %0b expected 0", read_data_valid); end
      n_checks++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", frame_busy); end
      n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", frame_done); end
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %0b expected 0", timeout); end
      n_checks++; if (line_count !== '0) begin n_fail++; $display("FAIL reset_line_count: got %0d expected 0", line_count); end
      n_checks++; if (out_pix_count !== '0) begin n_fail++; $display("FAIL reset_out_pix: got %0d expected 0", out_pix_count); end
      rx_fifo_capacity = '0;
      sobel_valid = 1'b0;
      reset = 1'b0;
      tick(2);
   endtask

   task automatic test_single_line();
      do_reset();
      rx_fifo_capacity = 14'd7;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         n_checks++;
         if (read_req !== 1'b0) begin n_fail++; $display("FAIL cap7_no_read: got %0b expected 0 (cycle %0d)", read_req, i); end
      end
      rx_fifo_capacity = 14'd8;
      exp_lines.push_back(1);
      tick(1);
      n_checks++; if (read_req !== 1'b1) begin n_fail++; $display("FAIL cap8_read_start: got %0b expected 1", read_req); end
      rx_fifo_capacity = 14'd7;
      tick(12);
      n_checks++; if (line_count !== 10'd1) begin n_fail++; $display("FAIL single_line_count: got %0d expected 1", line_count); end
      n_checks++; if (frame_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %0b expected 1", frame_busy); end
      n_checks++; if (exp_lines.size() !== 0) begin n_fail++; $display("FAIL single_pending: got %0d expected 0", exp_lines.size()); end
   endtask

   task automatic test_credits();
      do_reset();
      for (int i = 1; i <= 4; i++) exp_lines.push_back(i);
      rx_fifo_capacity = 14'd64;
      tick(50);
      n_checks++; if (line_count !== 10'd4) begin n_fail++; $display("FAIL credit_stall_count: got %0d expected 4", line_count); end
      n_checks++; if (exp_lines.size() !== 0) begin n_fail++; $display("FAIL credit_pending: got %0d expected 0", exp_lines.size()); end
      tick(10);
      n_checks++; if (read_req !== 1'b0) begin n_fail++; $display("FAIL credit_stall_read: got %0b expected 0", read_req); end
      exp_lines.push_back(5);
      lb_intr = 1'b1;
      tick(1);
      lb_intr = 1'b0;
      tick(14);
      n_checks++; if (line_count !== 10'd5) begin n_fail++; $display("FAIL credit_one_more: got %0d expected 5", line_count); end
      n_checks++; if (exp_lines.size() !== 0) begin n_fail++; $display("FAIL credit_one_pending: got %0d expected 0", exp_lines.size()); end
   endtask

   // continues from the stalled state left by test_credits (line_count 5, no credits)
   task automatic test_frame_done();
      bit ok;
      exp_lines.push_back(6);
      lb_intr = 1'b1;
      tick(1);
      lb_intr = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (read_req === 1'b1) begin ok = 1'b1; break; end
      end
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL last_burst_start: got %0b expected 1", ok); end
      rx_fifo_capacity = '0;
      lb_intr = 1'b1;
      tick(1);
      lb_intr = 1'b0;
      tick(10);
      n_checks++; if (line_count !== 10'd6) begin n_fail++; $display("FAIL last_line_count: got %0d expected 6", line_count); end
      n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL drain_done_early: got %0b expected 0", frame_done); end
      n_checks++; if (exp_lines.size() !== 0) begin n_fail++; $display("FAIL last_pending: got %0d expected 0", exp_lines.size()); end
      sobel_valid = 1'b1;
      tick(23);
      sobel_valid = 1'b0;
      tick(3);
      n_checks++; if (out_pix_count !== 18'd23) begin n_fail++; $display("FAIL drain_count23: got %0d expected 23", out_pix_count); end
      n_checks++; if (frame_done !== 1'b0 || frame_busy !== 1'b1) begin n_fail++; $display("FAIL drain_wait: got done %0b busy %0b expected done 0 busy 1", frame_done, frame_busy); end
      sobel_valid = 1'b1;
      tick(1);
      sobel_valid = 1'b0;
      n_checks++; if (out_pix_count !== 18'd24 || frame_done !== 1'b0) begin n_fail++; $display("FAIL drain_reach: got count %0d done %0b expected 24 0", out_pix_count, frame_done); end
      tick(1);
      n_checks++; if (frame_done !== 1'b1 || frame_busy !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got done %0b busy %0b expected 1 1", frame_done, frame_busy); end
      tick(1);
      n_checks++; if (frame_done !== 1'b0 || frame_busy !== 1'b0) begin n_fail++; $display("FAIL done_end: got done %0b busy %0b expected 0 0", frame_done, frame_busy); end
      n_checks++; if (line_count !== '0 || out_pix_count !== '0) begin n_fail++; $display("FAIL idle_clear: got line %0d pix %0d expected 0 0", line_count, out_pix_count); end
      sobel_valid = 1'b1;
      lb_intr = 1'b1;
      tick(5);
      sobel_valid = 1'b0;
      lb_intr = 1'b0;
      tick(1);
      n_checks++; if (out_pix_count !== '0 || frame_busy !== 1'b0) begin n_fail++; $display("FAIL idle_ignore: got pix %0d busy %0b expected 0 0", out_pix_count, frame_busy); end
   endtask

   task automatic test_credit_saturation();
      do_reset();
      exp_lines.push_back(1);
      rx_fifo_capacity = 14'd8;
      tick(1);
      rx_fifo_capacity = '0;
      tick(12);
      n_checks++; if (line_count !== 10'd1) begin n_fail++; $display("FAIL sat_first_line: got %0d expected 1", line_count); end
      for (int i = 0; i < 3; i++) begin
         lb_intr = 1'b1;
         tick(1);
         lb_intr = 1'b0;
         tick(1);
      end
      for (int i = 2; i <= 5; i++) exp_lines.push_back(i);
      rx_fifo_capacity = 14'd64;
      tick(50);
      n_checks++; if (line_count !== 10'd5) begin n_fail++; $display("FAIL sat_line_count: got %0d expected 5", line_count); end
      tick(10);
      n_checks++; if (read_req !== 1'b0 || line_count !== 10'd5) begin n_fail++; $display("FAIL sat_stall: got rr %0b line %0d expected 0 5", read_req, line_count); end
      n_checks++; if (exp_lines.size() !== 0) begin n_fail++; $display("FAIL sat_pending: got %0d expected 0", exp_lines.size()); end
      rx_fifo_capacity = '0;
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      do_reset();
      rx_fifo_capacity = 14'd64;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (read_req === 1'b1) begin ok = 1'b1; break; end
      end
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_burst_start: got %0b expected 1", ok); end
      tick(2);
      n_checks++; if (read_req !== 1'b1 || read_data_valid !== 1'b1) begin n_fail++; $display("FAIL mid_burst_active: got rr %0b rdv %0b expected 1 1", read_req, read_data_valid); end
      mon_en = 1'b0;
      reset = 1'b1;
      #1;
      n_checks++; if (read_req !== 1'b0 || read_data_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_rr: got rr %0b rdv %0b expected 0 0", read_req, read_data_valid); end
      rx_fifo_capacity = '0;
      tick(2);
      exp_lines.delete();
      reset = 1'b0;
      tick(1);
      mon_en = 1'b1;
      n_checks++; if (line_count !== '0 || frame_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_state: got line %0d busy %0b expected 0 0", line_count, frame_busy); end
      for (int i = 1; i <= 4; i++) exp_lines.push_back(i);
      rx_fifo_capacity = 14'd64;
      tick(50);
      n_checks++; if (line_count !== 10'd4) begin n_fail++; $display("FAIL post_reset_credits: got %0d expected 4", line_count); end
      n_checks++; if (exp_lines.size() !== 0) begin n_fail++; $display("FAIL post_reset_pending: got %0d expected 0", exp_lines.size()); end
      rx_fifo_capacity = '0;
   endtask

   task automatic test_timeout();
      bit ok;
      do_reset();
      exp_lines.push_back(1);
      rx_fifo_capacity = 14'd8;
      tick(1);
      rx_fifo_capacity = '0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (read_req === 1'b0) begin ok = 1'b1; break; end
      end
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL to_burst_end: got %0b expected 1", ok); end
`ifdef FRAME_TIMEOUT_EN
      begin
         int n;
         bit got;
         bit seen_done;
         n = 0;
         got = 1'b0;
         seen_done = 1'b0;
         for (int i = 0; i < 200; i++) begin
            tick(1);
            n++;
            if (frame_done === 1'b1) seen_done = 1'b1;
            if (timeout === 1'b1) begin got = 1'b1; break; end
         end
         n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL timeout_seen: got %0b expected 1", got); end
         n_checks++; if (n < TIMEOUT_CYC - 1 || n > TIMEOUT_CYC + 1) begin n_fail++; $display("FAIL timeout_delay: got %0d expected %0d", n, TIMEOUT_CYC); end
         n_checks++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %0b expected 0", frame_busy); end
         n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL timeout_no_done: got %0b expected 0", seen_done); end
         tick(1);
         n_checks++; if (timeout !== 1'b0 || line_count !== '0) begin n_fail++; $display("FAIL timeout_pulse_end: got to %0b line %0d expected 0 0", timeout, line_count); end
      end
`else
      begin
         bit seen_to;
         seen_to = 1'b0;
         for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (timeout !== 1'b0) seen_to = 1'b1;
         end
         n_checks++; if (seen_to !== 1'b0) begin n_fail++; $display("FAIL no_timeout: got %0b expected 0", seen_to); end
         n_checks++; if (frame_busy !== 1'b1 || line_count !== 10'd1) begin n_fail++; $display("FAIL wait_forever: got busy %0b line %0d expected 1 1", frame_busy, line_count); end
      end
`endif
      n_checks++; if (exp_lines.size() !== 0) begin n_fail++; $display("FAIL to_pending: got %0d expected 0", exp_lines.size()); end
   endtask

   initial begin
      reset = 1'b1;
      rx_fifo_capacity = '0;
      lb_intr = 1'b0;
      sobel_valid = 1'b0;
      test_reset();
      test_single_line();
      test_credits();
      test_frame_done();
      test_credit_saturation();
      test_reset_mid_burst();
      test_timeout();
      mon_en = 1'b0;
      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame-level controller for the receive-side Sobel pipeline. It meters pixel bytes out of the UART RX FIFO into the line buffer one full line at a time, using a credit count of free line-buffer rows. It counts lines in and Sobel results out, and flags frame completion. It sits between the RX FIFO (capacity/read-request) and the line buffer (pixel-valid in, line-consumed interrupt back), and observes the Sobel output valid.

## Interface
- IMG_W, 512, pixels per line (bytes per burst)
- IMG_H, 512, lines per frame
- LB_LINES, 4, physical line-buffer rows; initial credit count
- OUT_PIX, 261120, Sobel results expected per frame (510 x 512)
- TIMEOUT_CYC, 1000000, stall limit in cycles (only with FRAME_TIMEOUT_EN)
- LINE_W, 10, width of line_count
- OPIX_W, 18, width of out_pix_count

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- rx_fifo_capacity  in  14  bytes currently held in RX FIFO
- read_req  out  1  FIFO read strobe, one byte per cycle
- read_data_valid  out  1  read_req delayed one cycle (FIFO read latency 1), drives line-buffer pixel valid
- lb_intr  in  1  one-cycle pulse: line buffer freed one row
- sobel_valid  in  1  Sobel output valid
- frame_busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- timeout  out  1  one-cycle pulse on stall abort (0 without macro)
- line_count  out  LINE_W  lines written to line buffer this frame
- out_pix_count  out  OPIX_W  Sobel results counted this frame

## Operation
- States: IDLE, WAIT, BURST, DRAIN, DONE.
- IDLE: counters at 0, credits = LB_LINES. Go to BURST when rx_fifo_capacity >= IMG_W.
- BURST: read_req high for exactly IMG_W consecutive cycles; column counter runs 0..IMG_W-1. One credit is consumed on the first cycle. On the last cycle line_count increments. Next state is DRAIN if the new line_count == IMG_H, else WAIT.
- WAIT: go to BURST when credits > 0 and rx_fifo_capacity >= IMG_W. Because a burst starts only when the full line is buffered, the FIFO cannot underflow.
- Credits: range 0..LB_LINES. lb_intr adds 1, saturating at LB_LINES; an extra pulse is dropped. lb_intr in the same cycle as a burst start leaves credits unchanged.
- out_pix_count increments on every sobel_valid in any state except IDLE and DONE. It saturates at all-ones.
- DRAIN: go to DONE when out_pix_count >= OUT_PIX. If the count is already reached on entry, go to DONE on the next cycle.
- DONE: frame_done = 1 for one cycle, then IDLE. Counters clear on entry to IDLE.
- sobel_valid and lb_intr in IDLE have no effect on counters. lb_intr still restores credits, clamped at LB_LINES.

## Timing
- All outputs are registered. Reset values: read_req 0, read_data_valid 0, frame_busy 0, frame_done 0, timeout 0, line_count 0, out_pix_count 0. Internally: credits LB_LINES, state IDLE.
- Condition sampled at cycle N gives read_req = 1 from cycle N+1; read_data_valid follows read_req by exactly 1 cycle.
- There is at least one cycle of read_req = 0 between consecutive bursts.
- frame_done asserts the cycle after out_pix_count reaches OUT_PIX in DRAIN. frame_busy drops the same cycle frame_done drops.
- Reset mid-burst: read_req and read_data_valid fall immediately (asynchronously); all state returns to reset values; no partial line is accounted.

## Configuration
- FRAME_TIMEOUT_EN defined:
  - A stall counter clears on any cycle with read_req or sobel_valid high, or in IDLE; otherwise it increments.
  - When it reaches TIMEOUT_CYC: timeout pulses for 1 cycle, state goes to IDLE, counters clear, credits reload to LB_LINES. frame_done does not assert.
- FRAME_TIMEOUT_EN undefined: no stall counter is built, timeout is tied 0, and the sequencer waits indefinitely.

## Test plan
Run with IMG_W=8, IMG_H=6, LB_LINES=4, OUT_PIX=24, TIMEOUT_CYC=100.
- Capacity held at 7, then raised to 8 → read_req stays 0 until the cycle after capacity = 8, then exactly 8 cycles high; read_data_valid is the same pattern one cycle later; line_count = 1.
- Capacity held at 64, no lb_intr → 4 bursts, then stall in WAIT with line_count = 4. One lb_intr → exactly one more burst (line_count = 5).
- lb_intr coincident with the 6th burst start, 24 sobel_valid pulses after the last line → line_count = 6, DRAIN, frame_done pulse on the cycle after the 24th valid, state IDLE, counters 0.
- Two lb_intr pulses with credits = LB_LINES → credits remain 4; exactly 4 bursts are possible before the stall.
- Reset asserted on the 3rd cycle of a burst → read_req = 0 immediately; after release, line_count = 0 and credits = 4.
- FRAME_TIMEOUT_EN: stall in WAIT for 100 cycles → timeout pulse, frame_busy = 0, no frame_done. Without the macro, timeout stays 0 for 1000 cycles.
